// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser:
// parser states, command codes and reply bytes.
package cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        GET_TYPE,
        GET_SPEED,
        GET_FLAGS,
        GET_CSUM
    } state_e;

    localparam logic [7:0] CMD_MOVE     = 8'h01;
    localparam logic [7:0] CMD_STOP     = 8'h02;
    localparam logic [7:0] CMD_PING     = 8'h03;
    localparam logic [7:0] ACK_BYTE     = 8'h55;
    localparam logic [7:0] NACK_BYTE    = 8'hEE;
    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

    function automatic logic [7:0] clamp_speed(
        input logic [7:0] s,
        input logic [7:0] lim
    );
        return (s > lim) ? lim : s;
    endfunction

    function automatic logic known_type(input logic [7:0] t);
        return t inside {CMD_MOVE, CMD_STOP, CMD_PING};
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle of the UART command parser.
// The parser is the slave; the UART/motor side is the master.
interface uart_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_type;
    logic [7:0] cmd_speed;
    logic       cmd_dir;
    logic       cmd_valid;
    logic       heartbeat;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  cmd_type, cmd_speed, cmd_dir, cmd_valid,
        input  heartbeat, frame_err, err_cnt, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output cmd_type, cmd_speed, cmd_dir, cmd_valid,
        output heartbeat, frame_err, err_cnt, tx_data, tx_valid
    );

endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle counter: clears on each byte, runs while enabled,
// and pulses expire_o in the cycle the count would reach TIMEOUT_CYCLES.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // A byte in the expiry cycle clears the count, so it always wins.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART byte stream to validated motor commands with checksum and timeout.
// Define CMD_ACK_EN to return an ACK/NACK byte for every checked frame.
module uart_cmd_parser
    import cmd_pkg::*;
#(
    parameter logic [7:0]  MAX_SPEED      = 8'd200,
    parameter int unsigned TIMEOUT_CYCLES = 12000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    uart_cmd_parser_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] type_q, type_d;
    logic [7:0] speed_q, speed_d;
    logic [7:0] flags_q, flags_d;

    logic [7:0] cmd_type_q, cmd_speed_q, err_cnt_q;
    logic       cmd_dir_q, cmd_valid_q, heartbeat_q, frame_err_q;

    logic tmo_expire;
    logic csum_byte, csum_ok, accept, nack, update, err;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (bus.rx_valid),
        .en_i     (state_q != HUNT),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            type_q  <= '0;
            speed_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            speed_q <= speed_d;
            flags_q <= flags_d;
        end
    end

    // A sync value seen mid-frame is plain data; no resync.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        speed_d = speed_q;
        flags_d = flags_q;
        if (tmo_expire) begin
            state_d = HUNT;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.rx_data == SYNC_BYTE) state_d = GET_TYPE;
                end
                GET_TYPE: begin
                    type_d  = bus.rx_data;
                    state_d = GET_SPEED;
                end
                GET_SPEED: begin
                    speed_d = bus.rx_data;
                    state_d = GET_FLAGS;
                end
                GET_FLAGS: begin
                    flags_d = bus.rx_data;
                    state_d = GET_CSUM;
                end
                GET_CSUM: state_d = HUNT;
                default:  state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        csum_byte = bus.rx_valid && (state_q == GET_CSUM);
        csum_ok   = bus.rx_data == (type_q ^ speed_q ^ flags_q);
        accept    = csum_byte && csum_ok && known_type(type_q);
        nack      = csum_byte && !accept;
        update    = accept && (type_q != CMD_PING);
        err       = nack || tmo_expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_type_q  <= '0;
            cmd_speed_q <= '0;
            cmd_dir_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            heartbeat_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cmd_valid_q <= update;
            heartbeat_q <= accept;
            frame_err_q <= err;
            if (update) begin
                cmd_type_q  <= type_q;
                cmd_speed_q <= (type_q == CMD_STOP) ? 8'd0
                             : clamp_speed(speed_q, MAX_SPEED);
                cmd_dir_q   <= flags_q[0];
            end
            if (err && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.cmd_type  = cmd_type_q;
    assign bus.cmd_speed = cmd_speed_q;
    assign bus.cmd_dir   = cmd_dir_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.heartbeat = heartbeat_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;

`ifdef CMD_ACK_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    // A fresh outcome replaces a byte still waiting for the UART.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else if (accept || nack) begin
            tx_data_q  <= accept ? ACK_BYTE : NACK_BYTE;
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
`else
    logic unused_tx_ready;

    assign unused_tx_ready = bus.tx_ready;
    assign bus.tx_data     = '0;
    assign bus.tx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table, timeout/reset corner cases
// and random frames against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int TMO = 12000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .MAX_SPEED      (8'd200),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hAA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int mon_cv = 0;
    int mon_hb = 0;
    int mon_fe = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid) mon_cv++;
            if (bus.heartbeat) mon_hb++;
            if (bus.frame_err) mon_fe++;
        end
    end

    // Reference model: collect the four bytes after a sync, judge the frame.
    bit         m_in = 1'b0;
    logic [7:0] m_buf[$];
    logic [7:0] m_type = 8'h00;
    logic [7:0] m_speed = 8'h00;
    logic       m_dir = 1'b0;
    int         m_err = 0;
    int         m_cv = 0;
    int         m_hb = 0;
    int         m_fe = 0;

    function automatic void model_err();
        m_fe++;
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_frame();
        logic [7:0] t, s, f, c;
        t = m_buf[0];
        s = m_buf[1];
        f = m_buf[2];
        c = m_buf[3];
        if (((t ^ s ^ f) == c) && (t >= 8'd1) && (t <= 8'd3)) begin
            m_hb++;
            if (t != 8'd3) begin
                m_cv++;
                m_type  = t;
                m_speed = (t == 8'd2) ? 8'd0 : ((s > 8'd200) ? 8'd200 : s);
                m_dir   = f[0];
            end
        end else begin
            model_err();
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_in) begin
            if (b == 8'hAA) begin
                m_in = 1'b1;
                m_buf.delete();
            end
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                model_frame();
                m_in = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled by the following posedge.
    task automatic put(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_frame(input logic [39:0] fr);
        for (int k = 0; k < 5; k++) put(fr[39-8*k -: 8]);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " type"}, int'(bus.cmd_type), int'(m_type));
        chk({tag, " speed"}, int'(bus.cmd_speed), int'(m_speed));
        chk({tag, " dir"}, int'(bus.cmd_dir), int'(m_dir));
        chk({tag, " err_cnt"}, int'(bus.err_cnt), m_err);
        chk({tag, " n_cmd_valid"}, mon_cv, m_cv);
        chk({tag, " n_heartbeat"}, mon_hb, m_hb);
        chk({tag, " n_frame_err"}, mon_fe, m_fe);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " type"}, int'(bus.cmd_type), 0);
        chk({tag, " speed"}, int'(bus.cmd_speed), 0);
        chk({tag, " dir"}, int'(bus.cmd_dir), 0);
        chk({tag, " cmd_valid"}, int'(bus.cmd_valid), 0);
        chk({tag, " heartbeat"}, int'(bus.heartbeat), 0);
        chk({tag, " frame_err"}, int'(bus.frame_err), 0);
        chk({tag, " err_cnt"}, int'(bus.err_cnt), 0);
        chk({tag, " tx_valid"}, int'(bus.tx_valid), 0);
        chk({tag, " tx_data"}, int'(bus.tx_data), 0);
    endtask

    typedef struct {
        logic [39:0] fr;
        int          cv;
        int          hb;
        int          fe;
        logic [7:0]  typ;
        logic [7:0]  spd;
        logic        dir;
        int          err;
    } vec_t;

    vec_t       vecs[12];
    int         seen;
    int         r;
    logic [7:0] t, s, fl, c;

    initial begin
        vecs[0]  = '{40'hAA_01_64_01_64, 1, 1, 0, 8'h01, 8'd100, 1'b1, 0};
        vecs[1]  = '{40'hAA_01_FA_00_FB, 1, 1, 0, 8'h01, 8'd200, 1'b0, 0};
        vecs[2]  = '{40'hAA_01_10_00_00, 0, 0, 1, 8'h01, 8'd200, 1'b0, 1};
        vecs[3]  = '{40'hAA_03_00_00_03, 0, 1, 0, 8'h01, 8'd200, 1'b0, 1};
        vecs[4]  = '{40'hAA_02_33_00_31, 1, 1, 0, 8'h02, 8'd0,   1'b0, 1};
        vecs[5]  = '{40'hAA_07_10_01_16, 0, 0, 1, 8'h02, 8'd0,   1'b0, 2};
        vecs[6]  = '{40'hAA_01_C8_01_C8, 1, 1, 0, 8'h01, 8'd200, 1'b1, 2};
        vecs[7]  = '{40'hAA_01_C9_00_C8, 1, 1, 0, 8'h01, 8'd200, 1'b0, 2};
        vecs[8]  = '{40'hAA_01_AA_00_AB, 1, 1, 0, 8'h01, 8'd170, 1'b0, 2};
        vecs[9]  = '{40'hAA_02_FF_FF_02, 1, 1, 0, 8'h02, 8'd0,   1'b1, 2};
        vecs[10] = '{40'hAA_03_00_00_00, 0, 0, 1, 8'h02, 8'd0,   1'b1, 3};
        vecs[11] = '{40'hAA_00_00_00_00, 0, 0, 1, 8'h02, 8'd0,   1'b1, 4};

        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        idle(3);
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 4; k++) put(vecs[i].fr[39-8*k -: 8]);
            chk($sformatf("v%0d early_pulse", i),
                int'(bus.cmd_valid | bus.heartbeat | bus.frame_err), 0);
            put(vecs[i].fr[7:0]);
            chk($sformatf("v%0d cmd_valid", i), int'(bus.cmd_valid), vecs[i].cv);
            chk($sformatf("v%0d heartbeat", i), int'(bus.heartbeat), vecs[i].hb);
            chk($sformatf("v%0d frame_err", i), int'(bus.frame_err), vecs[i].fe);
            chk($sformatf("v%0d type", i), int'(bus.cmd_type), int'(vecs[i].typ));
            chk($sformatf("v%0d speed", i), int'(bus.cmd_speed), int'(vecs[i].spd));
            chk($sformatf("v%0d dir", i), int'(bus.cmd_dir), int'(vecs[i].dir));
            chk($sformatf("v%0d err_cnt", i), int'(bus.err_cnt), vecs[i].err);
`ifndef CMD_ACK_EN
            chk($sformatf("v%0d tx_off", i), int'({bus.tx_valid, bus.tx_data}), 0);
`endif
            idle(1);
            chk($sformatf("v%0d pulse_width", i),
                int'(bus.cmd_valid | bus.heartbeat | bus.frame_err), 0);
            idle(1);
        end
        chk_state("table");

`ifdef CMD_ACK_EN
        bus.tx_ready = 1'b0;
        put_frame(40'hAA_01_10_00_00);
        chk("ack nack_valid", int'(bus.tx_valid), 1);
        chk("ack nack_data", int'(bus.tx_data), 8'hEE);
        idle(3);
        chk("ack nack_hold", int'({bus.tx_valid, bus.tx_data}), 9'h1EE);
        put_frame(40'hAA_01_64_01_64);
        chk("ack overwrite", int'({bus.tx_valid, bus.tx_data}), 9'h155);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("ack drained", int'(bus.tx_valid), 0);
        idle(2);
        chk_state("ack");
`endif

        // Timeout after a partial frame, then a STOP frame from HUNT.
        put(8'hAA);
        put(8'h01);
        seen = 0;
        for (int i = 1; i <= TMO + 50; i++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                seen = i;
                break;
            end
        end
        chk("timeout latency", seen, TMO);
        m_in = 1'b0;
        model_err();
        chk("timeout err_cnt", int'(bus.err_cnt), m_err);
        chk("timeout no_cmd", int'(bus.cmd_valid | bus.heartbeat), 0);
        idle(2);
        put_frame(40'hAA_02_33_00_31);
        chk("stop speed", int'(bus.cmd_speed), 0);
        chk("stop valid", int'(bus.cmd_valid), 1);
        idle(2);
        chk_state("timeout");

        // Byte arriving in the cycle the timer would expire keeps the frame.
        put(8'hAA);
        put(8'h01);
        idle(TMO - 1);
        put(8'h20);
        put(8'h01);
        put(8'h20);
        chk("edge accepted", int'(bus.cmd_valid), 1);
        idle(2);
        chk_state("edge");

        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) put(8'($urandom_range(0, 169)));
            r = int'($urandom_range(0, 7));
            if (r < 3)       t = 8'h01;
            else if (r < 5)  t = 8'h02;
            else if (r == 5) t = 8'h03;
            else             t = 8'($urandom);
            s  = 8'($urandom);
            fl = 8'($urandom);
            c  = t ^ s ^ fl;
            if ($urandom_range(0, 3) == 0) c = 8'($urandom);
            put(8'hAA); idle(int'($urandom_range(0, 2)));
            put(t);     idle(int'($urandom_range(0, 2)));
            put(s);     idle(int'($urandom_range(0, 2)));
            put(fl);    idle(int'($urandom_range(0, 2)));
            put(c);
            idle(2);
            chk_state($sformatf("rand%0d", f));
        end

        // Reset in mid-frame, then the frame tail must be ignored.
        put(8'hAA);
        put(8'h01);
        put(8'h64);
        rst_n = 1'b0;
        idle(2);
        chk_zero("midreset");
        m_in    = 1'b0;
        m_type  = 8'h00;
        m_speed = 8'h00;
        m_dir   = 1'b0;
        m_err   = 0;
        rst_n = 1'b1;
        idle(1);
        put(8'h01);
        put(8'h64);
        idle(TMO + 10);
        chk_zero("postreset");
        chk_state("postreset");

        for (int i = 0; i < 256; i++) put_frame(40'hAA_01_10_00_00);
        idle(2);
        chk("sat err_cnt", int'(bus.err_cnt), 255);
        put_frame(40'hAA_01_10_00_00);
        chk("sat pulse", int'(bus.frame_err), 1);
        chk("sat hold", int'(bus.err_cnt), 255);
        idle(2);
        chk_state("sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
